// File: rtl/mips_pkg.sv
// Shared MIPS definitions: widths, opcodes, fetch payload and target calculation.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam word_t NOP_WORD         = WORD_W'(0);
  localparam addr_t RESET_PC_DEFAULT = ADDR_W'(0);

  // One buffered fetch: instruction word plus the PC it was read from
  typedef struct packed {
    word_t word;
    addr_t pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DROP = 1'b1
  } fetch_state_e;

  // beq target: sequential PC plus sign-extended word offset
  function automatic addr_t branch_target(input addr_t seq, input word_t instr);
    return seq + {{14{instr[15]}}, instr[15:0], 2'b00};
  endfunction

  // j target: region bits of sequential PC with the 26-bit word index
  function automatic addr_t jump_target(input addr_t seq, input word_t instr);
    return {seq[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory handshake plus decoder-facing head entry.
interface instr_fetch_if import mips_pkg::*; ;

  logic  imem_req;
  addr_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;
  word_t ins;
  addr_t ins_pc;
  logic  ins_valid;
  logic  ins_ready;
  logic  branch_taken;
  logic  jump;

  modport master (
    output imem_req, imem_addr, ins, ins_pc, ins_valid,
    input  imem_ack, imem_rdata, ins_ready, branch_taken, jump
  );

  modport slave (
    input  imem_req, imem_addr, ins, ins_pc, ins_valid,
    output imem_ack, imem_rdata, ins_ready, branch_taken, jump
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {word, pc} buffer between instruction memory and decode.
module fetch_fifo import mips_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // Pointer and occupancy tracking; flush empties the buffer in one cycle
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  // Storage needs no reset; contents are qualified by r_count
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_valid = (r_count != 2'd0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, requests words, buffers two, redirects on beq/j.
module instr_fetch import mips_pkg::*; #(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  addr_t        r_fetch_pc;
  addr_t        w_fetch_pc_nxt;
  addr_t        r_drop_addr;
  addr_t        w_drop_addr_nxt;

  fetch_entry_t w_head;
  fetch_entry_t w_entry;
  logic         w_head_valid;
  logic [1:0]   w_count;
  logic         w_req;
  logic         w_xfer;
  logic         w_consume;
  logic         w_redirect;
  logic         w_push;
  logic         w_pop;
  addr_t        w_seq;
  addr_t        w_target;

  // Request depends only on registered state, never on ins_ready
  assign w_req  = !rst && ((r_state == ST_DROP) || (w_count < 2'd2));
  assign w_xfer = w_req && bus.imem_ack;

  assign w_consume  = w_head_valid && bus.ins_ready;
  assign w_redirect = w_consume && (bus.branch_taken || bus.jump);
  assign w_seq      = w_head.pc + ADDR_W'(4);
  assign w_target   = bus.jump ? jump_target(w_seq, w_head.word)
                               : branch_target(w_seq, w_head.word);

  // Words returned in a redirect cycle or while draining a stale request are dropped
  assign w_push  = w_xfer && (r_state == ST_RUN) && !w_redirect;
  assign w_pop   = w_consume && !w_redirect;
  assign w_entry = '{word: bus.imem_rdata, pc: r_fetch_pc};

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_head  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_count)
  );

  // Next-state and PC update; DROP keeps the stale address on the bus until acked
  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_drop_addr_nxt = r_drop_addr;
    case (r_state)
      ST_RUN: begin
        if (w_redirect) begin
          w_fetch_pc_nxt = w_target;
          if (w_req && !bus.imem_ack) begin
            w_state_nxt     = ST_DROP;
            w_drop_addr_nxt = r_fetch_pc;
          end
        end else if (w_xfer) begin
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
        end
      end
      ST_DROP: begin
        if (w_xfer) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= ADDR_W'(0);
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_drop_addr <= w_drop_addr_nxt;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = (r_state == ST_DROP) ? r_drop_addr : r_fetch_pc;
  assign bus.ins       = w_head.word;
  assign bus.ins_pc    = w_head.pc;
  assign bus.ins_valid = w_head_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of presented {ins, ins_pc} plus per-scenario checks.
module tb_instr_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch #(.RESET_PC(32'h3000_0020)) u_dut_j (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_vec = 0;
  int n_err = 0;
  fetch_entry_t q[$];
  fetch_entry_t q2[$];
  fetch_entry_t e1;
  fetch_entry_t e2;
  addr_t br_pc = 32'hFFFF_FFFF;

  // Memory image: word = address, except a beq at 0x10 and a j at 0x3000_0020
  function automatic word_t mem_word(input addr_t a);
    case (a)
      32'h0000_0010: return 32'h1000_FFFC;
      32'h3000_0020: return 32'h0800_0040;
      default:       return word_t'(a);
    endcase
  endfunction

  task automatic exp_push(input addr_t pc);
    q.push_back('{word: mem_word(pc), pc: pc});
  endtask

  task automatic exp_push2(input addr_t pc);
    q2.push_back('{word: mem_word(pc), pc: pc});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory data and decoder model, driven on the falling edge
  initial begin
    bus.imem_rdata = '0;  bus.branch_taken = 1'b0;  bus.jump = 1'b0;
    bus2.imem_rdata = '0; bus2.branch_taken = 1'b0; bus2.jump = 1'b0;
    forever begin
      @(negedge clk);
      bus.imem_rdata    = mem_word(bus.imem_addr);
      bus.branch_taken  = bus.ins_valid && (bus.ins_pc == br_pc);
      bus.jump          = 1'b0;
      bus2.imem_rdata   = mem_word(bus2.imem_addr);
      bus2.jump         = bus2.ins_valid && (bus2.ins_pc == 32'h3000_0020);
      bus2.branch_taken = bus2.jump;
    end
  end

  // Scoreboard: every consumed head must match the next expected entry
  always @(negedge clk) begin
    if (!rst && bus.ins_valid === 1'b1 && bus.ins_ready === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected got pc=%h ins=%h expected none", bus.ins_pc, bus.ins);
      end else begin
        e1 = q.pop_front();
        if (bus.ins_pc !== e1.pc || bus.ins !== e1.word) begin
          n_err++;
          $display("FAIL sb_head got pc=%h ins=%h expected pc=%h ins=%h", bus.ins_pc, bus.ins, e1.pc, e1.word);
        end
      end
    end
    if (!rst && bus2.ins_valid === 1'b1 && bus2.ins_ready === 1'b1) begin
      n_vec++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL sb2_unexpected got pc=%h ins=%h expected none", bus2.ins_pc, bus2.ins);
      end else begin
        e2 = q2.pop_front();
        if (bus2.ins_pc !== e2.pc || bus2.ins !== e2.word) begin
          n_err++;
          $display("FAIL sb2_head got pc=%h ins=%h expected pc=%h ins=%h", bus2.ins_pc, bus2.ins, e2.pc, e2.word);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.ins_ready = 1'b0;  bus.imem_ack = 1'b0;
    bus2.ins_ready = 1'b0; bus2.imem_ack = 1'b1;
    br_pc = 32'hFFFF_FFFF;
    q.delete();
    q2.delete();
    cycle();
    cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ins_ready = 1'b1; bus.imem_ack = 1'b1;
    bus2.ins_ready = 1'b0; bus2.imem_ack = 1'b1;
    cycle();
    cycle();
    n_vec++; if (bus.ins_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b expected 0", bus.ins_valid); end
    n_vec++; if (bus.ins !== 32'h0) begin n_err++; $display("FAIL rst_ins got %h expected 0", bus.ins); end
    n_vec++; if (bus.ins_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h expected 0", bus.ins_pc); end
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b expected 0", bus.imem_req); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rst_first_req got req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
    bus.ins_ready = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    bus.imem_ack = 1'b1;
    bus.ins_ready = 1'b1;
    for (int k = 0; k < 7; k++) exp_push(addr_t'(4 * k));
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (i <= 4) begin
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr_t'(4 * i)) begin
          n_err++; $display("FAIL stream_addr[%0d] got req=%b addr=%h expected req=1 addr=%h", i, bus.imem_req, bus.imem_addr, 4 * i);
        end
        n_vec++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== addr_t'(4 * (i - 1))) begin
          n_err++; $display("FAIL stream_head[%0d] got valid=%b pc=%h expected valid=1 pc=%h", i, bus.ins_valid, bus.ins_pc, 4 * (i - 1));
        end
      end
    end
    bus.ins_ready = 1'b0;
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL stream_left got %0d expected 0", q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.imem_ack = 1'b1;
    bus.ins_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i == 1) begin
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
          n_err++; $display("FAIL bp_second_req got req=%b addr=%h expected req=1 addr=4", bus.imem_req, bus.imem_addr);
        end
      end
      if (i >= 2) begin
        n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_full[%0d] got %b expected 0", i, bus.imem_req); end
      end
    end
    n_vec++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0) begin
      n_err++; $display("FAIL bp_head got valid=%b pc=%h expected valid=1 pc=0", bus.ins_valid, bus.ins_pc);
    end
    for (int k = 0; k < 4; k++) exp_push(addr_t'(4 * k));
    bus.ins_ready = 1'b1;
    for (int i = 1; i <= 4; i++) cycle();
    bus.ins_ready = 1'b0;
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL bp_left got %0d expected 0", q.size()); end
  endtask

  task automatic test_branch();
    do_reset();
    br_pc = 32'h10;
    bus.imem_ack = 1'b1;
    bus.ins_ready = 1'b1;
    exp_push(32'h00); exp_push(32'h04); exp_push(32'h08); exp_push(32'h0C);
    exp_push(32'h10); exp_push(32'h04); exp_push(32'h08); exp_push(32'h0C);
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i == 6) begin
        n_vec++; if (bus.ins_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
          n_err++; $display("FAIL br_target_req got valid=%b req=%b addr=%h expected valid=0 req=1 addr=4", bus.ins_valid, bus.imem_req, bus.imem_addr);
        end
      end
      if (i == 7) begin
        n_vec++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h4) begin
          n_err++; $display("FAIL br_target_head got valid=%b pc=%h expected valid=1 pc=4", bus.ins_valid, bus.ins_pc);
        end
      end
    end
    bus.ins_ready = 1'b0;
    br_pc = 32'hFFFF_FFFF;
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL br_left got %0d expected 0", q.size()); end
  endtask

  task automatic test_jump();
    do_reset();
    bus2.ins_ready = 1'b1;
    exp_push2(32'h3000_0020);
    exp_push2(32'h3000_0100);
    exp_push2(32'h3000_0104);
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i == 2) begin
        n_vec++; if (bus2.ins_valid !== 1'b0 || bus2.imem_addr !== 32'h3000_0100) begin
          n_err++; $display("FAIL j_target_req got valid=%b addr=%h expected valid=0 addr=30000100", bus2.ins_valid, bus2.imem_addr);
        end
      end
    end
    bus2.ins_ready = 1'b0;
    n_vec++; if (q2.size() != 0) begin n_err++; $display("FAIL j_left got %0d expected 0", q2.size()); end
  endtask

  task automatic test_drop();
    do_reset();
    br_pc = 32'h10;
    bus.ins_ready = 1'b1;
    exp_push(32'h00); exp_push(32'h04); exp_push(32'h08); exp_push(32'h0C);
    exp_push(32'h10); exp_push(32'h04); exp_push(32'h08);
    for (int i = 1; i <= 12; i++) begin
      bus.imem_ack = (i >= 6 && i <= 8) ? 1'b0 : 1'b1;
      cycle();
      if (i >= 6 && i <= 8) begin
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14 || bus.ins_valid !== 1'b0) begin
          n_err++; $display("FAIL drop_hold[%0d] got req=%b addr=%h valid=%b expected req=1 addr=14 valid=0", i, bus.imem_req, bus.imem_addr, bus.ins_valid);
        end
      end
      if (i == 9) begin
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.ins_valid !== 1'b0) begin
          n_err++; $display("FAIL drop_release got req=%b addr=%h valid=%b expected req=1 addr=4 valid=0", bus.imem_req, bus.imem_addr, bus.ins_valid);
        end
      end
      if (i == 10) begin
        n_vec++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h4) begin
          n_err++; $display("FAIL drop_target_head got valid=%b pc=%h expected valid=1 pc=4", bus.ins_valid, bus.ins_pc);
        end
      end
    end
    bus.ins_ready = 1'b0;
    br_pc = 32'hFFFF_FFFF;
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL drop_left got %0d expected 0", q.size()); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.ins_ready = 1'b0;
    bus.imem_ack = 1'b1;
    cycle();
    bus.imem_ack = 1'b0;
    cycle();
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      n_err++; $display("FAIL rstmid_pending got req=%b addr=%h expected req=1 addr=4", bus.imem_req, bus.imem_addr);
    end
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    cycle();
    n_vec++; if (bus.ins_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL rstmid_clear got valid=%b req=%b expected valid=0 req=0", bus.ins_valid, bus.imem_req);
    end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rstmid_restart got req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
    exp_push(32'h0);
    exp_push(32'h4);
    bus.ins_ready = 1'b1;
    for (int i = 1; i <= 3; i++) cycle();
    bus.ins_ready = 1'b0;
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL rstmid_left got %0d expected 0", q.size()); end
  endtask

  initial begin
    bus.ins_ready = 1'b0;  bus.imem_ack = 1'b0;
    bus2.ins_ready = 1'b0; bus2.imem_ack = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_jump();
    test_drop();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
